// File: rtl/eu_icon_arbiter.sv
// Round-robin arbiter that binds NUM_UNITS producers onto NUM_CHANNELS registered result
// channels, holding a channel for its owner until the last beat of a multi-beat packet lands.
module eu_icon_arbiter #(
   parameter  int NUM_UNITS    = 4,
   parameter  int NUM_CHANNELS = 2,
   parameter  int DATA_WIDTH   = 32,
   localparam int ID_W         = $clog2(NUM_UNITS)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_UNITS-1:0]               req_valid,
   input  logic [NUM_UNITS*DATA_WIDTH-1:0]    req_data,
   input  logic [NUM_UNITS-1:0]               req_last,
   output logic [NUM_UNITS-1:0]               req_ready,
   output logic [NUM_CHANNELS-1:0]            ch_valid,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
   output logic [NUM_CHANNELS*ID_W-1:0]       ch_src,
   output logic [NUM_CHANNELS-1:0]            ch_last,
   input  logic [NUM_CHANNELS-1:0]            ch_ready,
   output logic [NUM_CHANNELS-1:0]            ch_bound
);

   // Handshake: a beat moves on req_valid[u] && req_ready[u] (producer side) and on
   // ch_valid[c] && ch_ready[c] (consumer side); valid never waits on ready.
   typedef enum logic {ST_IDLE = 1'b0, ST_BOUND = 1'b1} ch_state_t;

   ch_state_t               state_q   [NUM_CHANNELS];
   ch_state_t               state_d   [NUM_CHANNELS];
   logic [ID_W-1:0]         owner_q   [NUM_CHANNELS];
   logic [ID_W-1:0]         owner_d   [NUM_CHANNELS];
   logic [ID_W-1:0]         load_unit [NUM_CHANNELS];
   logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [NUM_CHANNELS-1:0] can_load, load, taken;
   logic [NUM_UNITS-1:0]    unit_bound, ready_raw;
   logic                    found;
   logic [ID_W-1:0]         cand;

   function automatic logic [ID_W-1:0] ring_add(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_UNITS) s = s - NUM_UNITS;
      return s[ID_W-1:0];
   endfunction

   always_comb begin
      can_load   = '0;
      unit_bound = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         can_load[c] = !ch_valid[c] || ch_ready[c];
         if (state_q[c] == ST_BOUND) unit_bound[owner_q[c]] = 1'b1;
      end
   end

   // Bound channels serve only their owner; idle loadable channels go to fresh candidates
   // in ring order starting at rr_ptr, lowest channel index first.
   always_comb begin
      ready_raw = '0;
      load      = '0;
      taken     = '0;
      found     = 1'b0;
      cand      = '0;
      rr_ptr_d  = rr_ptr_q;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         load_unit[c] = '0;
         if (state_q[c] == ST_BOUND) begin
            load_unit[c]          = owner_q[c];
            ready_raw[owner_q[c]] = can_load[c];
            load[c]               = can_load[c] && req_valid[owner_q[c]];
         end
      end
      for (int i = 0; i < NUM_UNITS; i++) begin
         cand  = ring_add(rr_ptr_q, i);
         found = 1'b0;
         if (req_valid[cand] && !unit_bound[cand]) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
               if (!found && state_q[c] == ST_IDLE && can_load[c] && !taken[c]) begin
                  found           = 1'b1;
                  taken[c]        = 1'b1;
                  load[c]         = 1'b1;
                  load_unit[c]    = cand;
                  ready_raw[cand] = 1'b1;
                  rr_ptr_d        = ring_add(cand, 1);
               end
            end
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         state_d[c] = state_q[c];
         owner_d[c] = owner_q[c];
         if (load[c]) begin
            if (state_q[c] == ST_BOUND) begin
               if (req_last[load_unit[c]]) state_d[c] = ST_IDLE;
            end else if (!req_last[load_unit[c]]) begin
               state_d[c] = ST_BOUND;
               owner_d[c] = load_unit[c];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q <= '0;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_q[c] <= ST_IDLE;
            owner_q[c] <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_q[c] <= state_d[c];
            owner_q[c] <= owner_d[c];
         end
      end
   end

   // Payload, source and last only change on a load, so a stalled beat stays stable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ch_valid <= '0;
         ch_data  <= '0;
         ch_src   <= '0;
         ch_last  <= '0;
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (load[c]) begin
               ch_valid[c]                         <= 1'b1;
               ch_data[c*DATA_WIDTH +: DATA_WIDTH] <= req_data[int'(load_unit[c])*DATA_WIDTH +: DATA_WIDTH];
               ch_src[c*ID_W +: ID_W]              <= load_unit[c];
               ch_last[c]                          <= req_last[load_unit[c]];
            end else if (ch_ready[c]) begin
               ch_valid[c] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      ch_bound = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) ch_bound[c] = (state_q[c] == ST_BOUND);
   end

   assign req_ready = reset ? '0 : ready_raw;

endmodule
